// File: rtl/riscv_pkg.sv
// Shared RISC-V constants used by the fetch-side branch predictor.
package riscv_pkg;

    // Opcodes of the control-flow instruction classes the predictor cares about
    localparam logic [6:0] bOp    = 7'h63;
    localparam logic [6:0] jalOp  = 7'h6F;
    localparam logic [6:0] jalrOp = 7'h67;

    // Two-bit saturating counter states; the MSB is the taken prediction
    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

endpackage : riscv_pkg

// File: rtl/sat_counter2.sv
// Next-state logic of a single two-bit saturating counter.
module sat_counter2
    import riscv_pkg::*;
(
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next
);

    // Step toward strong taken or strong not-taken, holding at either end
    always_comb begin
        next = state;
        if (taken) begin
            if (state != STRONG_T) begin
                next = state + 2'd1;
            end
        end else begin
            if (state != STRONG_NT) begin
                next = state - 2'd1;
            end
        end
    end

endmodule : sat_counter2

// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table of two-bit counters with mispredict
// flagging and branch/mispredict statistics.
module branch_predictor_bht
    import riscv_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetchPC,
    input  logic [6:0]  fetchOpCode,
    output logic        predictTaken,
    input  logic        updateValid,
    input  logic [31:0] updatePC,
    input  logic [6:0]  updateOpCode,
    input  logic        updateTaken,
    input  logic        updatePredicted,
    output logic        mispredict,
    output logic [31:0] branchCount,
    output logic [31:0] mispredictCount
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            counterTable [ENTRIES];
    logic [INDEX_BITS-1:0] fetchIdx;
    logic [INDEX_BITS-1:0] updateIdx;
    logic [1:0]            trainNext;
    logic                  trainEnable;
    logic                  mismatch;
    logic                  unusedPcBits;

    assign fetchIdx    = fetchPC[INDEX_BITS+1:2];
    assign updateIdx   = updatePC[INDEX_BITS+1:2];
    assign trainEnable = updateValid && (updateOpCode == bOp);
    assign mismatch    = updateValid && (updateTaken != updatePredicted);

    // PC bits outside the index field play no part in the lookup (no tags)
    assign unusedPcBits = ^{fetchPC[31:INDEX_BITS+2], fetchPC[1:0],
                            updatePC[31:INDEX_BITS+2], updatePC[1:0]};

    sat_counter2 trainCounter (
        .state (counterTable[updateIdx]),
        .taken (updateTaken),
        .next  (trainNext)
    );

    // Prediction reads only the registered table, so a same-cycle update is not visible
    always_comb begin
        predictTaken = 1'b0;
        if (fetchOpCode == jalOp || fetchOpCode == jalrOp) begin
            predictTaken = 1'b1;
        end else if (fetchOpCode == bOp) begin
            predictTaken = counterTable[fetchIdx][1];
        end
    end

    // Table: reset every entry to weak not-taken, otherwise train on resolved branches
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counterTable[i] <= WEAK_NT;
            end
        end else if (trainEnable) begin
            counterTable[updateIdx] <= trainNext;
        end
    end

    // Mispredict pulse and free-running wrap-around statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict      <= 1'b0;
            branchCount     <= 32'd0;
            mispredictCount <= 32'd0;
        end else begin
            mispredict <= mismatch;
            if (mismatch) begin
                mispredictCount <= mispredictCount + 32'd1;
            end
            if (trainEnable) begin
                branchCount <= branchCount + 32'd1;
            end
        end
    end

endmodule : branch_predictor_bht
